ip4_rtl_spa_dispatch: RTL and testbench



---
 rtl/ip4_rtl_spa_dispatch_pkg.sv | 43 ++++
 rtl/ip4_rtl_spa_dispatch_if.sv | 46 ++++
 rtl/ip4_rtl_spa_skid.sv | 74 +++++++
 rtl/ip4_rtl_spa_dispatch.sv | 154 +++++++++++++++
 tb/tb_ip4_rtl_spa_dispatch.sv | 298 +++++++++++++++++++++++++++++
 5 files changed

// File: rtl/ip4_rtl_spa_dispatch_pkg.sv
// ip4_rtl_spa_dispatch_pkg: shared types and constants for the SPA operand dispatcher.
//   opcode_e          SP operation code carried with every bundle
//   op_bundle_t       3x4 operand words for one register-file row
//   dispatch_state_e  dispatcher FSM states
//   sp_bundle_t       skid-buffer payload (operands, element index, last flag)
package ip4_rtl_spa_dispatch_pkg;

    localparam int unsigned IP4_SPA_MAX_VL       = 16;
    localparam int unsigned IP4_SPA_VL_W         = $clog2(IP4_SPA_MAX_VL);
    localparam int unsigned IP4_SPA_RA_W         = 8;
    localparam int unsigned IP4_WORD_W           = 32;
    localparam int unsigned IP4_SPA_ROWS         = 3;
    localparam int unsigned IP4_SPA_COLS         = 4;
    localparam int unsigned IP4_SPA_SKID_DEPTH   = 2;
    localparam int unsigned IP4_SPA_SKID_CNT_W   = $clog2(IP4_SPA_SKID_DEPTH + 1);

    typedef logic [IP4_WORD_W-1:0] wordu;
    typedef wordu [0:IP4_SPA_ROWS-1][0:IP4_SPA_COLS-1] op_bundle_t;

    typedef enum logic [3:0] {
        OP_NOP = 4'd0,
        OP_ADD = 4'd1,
        OP_SUB = 4'd2,
        OP_MUL = 4'd3,
        OP_MAC = 4'd4,
        OP_MIN = 4'd5,
        OP_MAX = 4'd6,
        OP_SHL = 4'd7
    } opcode_e;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        RUN   = 2'd1,
        DRAIN = 2'd2
    } dispatch_state_e;

    typedef struct packed {
        op_bundle_t                op;
        logic [IP4_SPA_VL_W-1:0]   idx;
        logic                      last;
    } sp_bundle_t;

endpackage

// File: rtl/ip4_rtl_spa_dispatch_if.sv
// ip4_rtl_spa_dispatch_if: issue, register-file read and SPA stream signals of the dispatcher.
//   master : dispatcher side (accepts issue, drives RF reads, offers SPA bundles)
//   slave  : environment side (issue stage, register file, SPA)
interface ip4_rtl_spa_dispatch_if
    import ip4_rtl_spa_dispatch_pkg::*;
#(
    parameter int unsigned VL_W = IP4_SPA_VL_W,
    parameter int unsigned RA_W = IP4_SPA_RA_W
);

    logic             iss_valid;
    logic             iss_ready;
    opcode_e          iss_opcode;
    logic [VL_W-1:0]  iss_vlm1;
    logic [RA_W-1:0]  iss_rbase;

    logic             rf_rd_en;
    logic [RA_W-1:0]  rf_rd_addr;
    op_bundle_t       rf_rd_data;

    logic             sp_valid;
    logic             sp_ready;
    opcode_e          sp_opcode;
    op_bundle_t       sp_op;
    logic [VL_W-1:0]  sp_idx;
    logic             sp_last;

    modport master (
        input  iss_valid, iss_opcode, iss_vlm1, iss_rbase,
        output iss_ready,
        output rf_rd_en, rf_rd_addr,
        input  rf_rd_data,
        output sp_valid, sp_opcode, sp_op, sp_idx, sp_last,
        input  sp_ready
    );

    modport slave (
        output iss_valid, iss_opcode, iss_vlm1, iss_rbase,
        input  iss_ready,
        input  rf_rd_en, rf_rd_addr,
        output rf_rd_data,
        input  sp_valid, sp_opcode, sp_op, sp_idx, sp_last,
        output sp_ready
    );

endinterface

// File: rtl/ip4_rtl_spa_skid.sv
// ip4_rtl_spa_skid: 2-entry FIFO of sp_bundle_t; head entry is a register so it can drive
// the SPA outputs directly.
//   clk, clr      clock and synchronous clear
//   push/push_data write port
//   pop           remove head entry
//   count         number of valid entries
//   head          oldest entry
module ip4_rtl_spa_skid
    import ip4_rtl_spa_dispatch_pkg::*;
(
    input  logic                          clk,
    input  logic                          clr,
    input  logic                          push,
    input  sp_bundle_t                    push_data,
    input  logic                          pop,
    output logic [IP4_SPA_SKID_CNT_W-1:0] count,
    output sp_bundle_t                    head
);

    localparam int unsigned CW = IP4_SPA_SKID_CNT_W;

    sp_bundle_t      head_q, head_d;
    sp_bundle_t      tail_q, tail_d;
    logic [CW-1:0]   count_q, count_d;
    logic            pop_ok_c;
    logic            push_ok_c;

    // Ignore pops on empty and pushes that would overflow.
    assign pop_ok_c  = pop && (count_q != '0);
    assign push_ok_c = push && ((count_q < CW'(IP4_SPA_SKID_DEPTH)) || pop_ok_c);

    // Head/tail shift: the new entry lands in head whenever head would otherwise be empty.
    always_comb begin
        head_d  = head_q;
        tail_d  = tail_q;
        count_d = count_q;
        case ({push_ok_c, pop_ok_c})
            2'b10: begin
                if (count_q == '0) head_d = push_data;
                else               tail_d = push_data;
                count_d = count_q + CW'(1);
            end
            2'b01: begin
                head_d  = tail_q;
                count_d = count_q - CW'(1);
            end
            2'b11: begin
                if (count_q == CW'(1)) begin
                    head_d = push_data;
                end else begin
                    head_d = tail_q;
                    tail_d = push_data;
                end
            end
            default: ;
        endcase
    end

    always_ff @(posedge clk) begin
        if (clr) begin
            head_q  <= '0;
            tail_q  <= '0;
            count_q <= '0;
        end else begin
            head_q  <= head_d;
            tail_q  <= tail_d;
            count_q <= count_d;
        end
    end

    assign count = count_q;
    assign head  = head_q;

endmodule

// File: rtl/ip4_rtl_spa_dispatch.sv
// ip4_rtl_spa_dispatch: accepts one vector instruction, reads VL consecutive register-file
// rows and streams them to the SPA as tagged operand bundles through a 2-entry skid buffer.
//   clk, rst   clock, synchronous active-high reset
//   bus        ip4_rtl_spa_dispatch_if.master (issue, RF read, SPA stream)
//   busy       high whenever the FSM is not IDLE
//   stall_cnt  saturating count of SPA stall cycles
// Optional feature: define IP4_SPA_DISPATCH_PERF_EN to build the stall counter;
// otherwise stall_cnt is tied to zero.
module ip4_rtl_spa_dispatch
    import ip4_rtl_spa_dispatch_pkg::*;
#(
    parameter int unsigned MAX_VL = IP4_SPA_MAX_VL,
    parameter int unsigned VL_W   = $clog2(MAX_VL),
    parameter int unsigned RA_W   = IP4_SPA_RA_W
)(
    input  logic                     clk,
    input  logic                     rst,
    ip4_rtl_spa_dispatch_if.master   bus,
    output logic                     busy,
    output logic [15:0]              stall_cnt
);

    dispatch_state_e  state_q, state_d;
    opcode_e          opcode_q, opcode_d;
    logic [VL_W-1:0]  vlm1_q, vlm1_d;
    logic [VL_W-1:0]  rd_cnt_q, rd_cnt_d;
    logic [RA_W-1:0]  addr_q, addr_d;
    logic             infl_q, infl_d;
    logic [VL_W-1:0]  infl_idx_q, infl_idx_d;
    logic             iss_ready_q, iss_ready_d;
    logic             busy_q, busy_d;

    logic [IP4_SPA_SKID_CNT_W-1:0] skid_cnt;
    sp_bundle_t                    skid_head;
    sp_bundle_t                    push_data_c;
    logic                          sp_valid_c;
    logic                          pop_c;
    logic [2:0]                    level_c;
    logic                          rd_en_c;

    assign sp_valid_c = (skid_cnt != '0);
    assign pop_c      = sp_valid_c && bus.sp_ready;

    // Buffered + in-flight rows after this cycle's pop; a new read only fits below 2.
    assign level_c = 3'(skid_cnt) + 3'(infl_q) - 3'(pop_c);
    assign rd_en_c = (state_q == RUN) && (level_c < 3'(IP4_SPA_SKID_DEPTH));

    // Returning row is tagged with the index recorded when its read was issued.
    always_comb begin
        push_data_c      = '0;
        push_data_c.op   = bus.rf_rd_data;
        push_data_c.idx  = IP4_SPA_VL_W'(infl_idx_q);
        push_data_c.last = (infl_idx_q == vlm1_q);
    end

    ip4_rtl_spa_skid u_skid (
        .clk       (clk),
        .clr       (rst),
        .push      (infl_q),
        .push_data (push_data_c),
        .pop       (pop_c),
        .count     (skid_cnt),
        .head      (skid_head)
    );

    // Next-state and instruction bookkeeping.
    always_comb begin
        state_d    = state_q;
        opcode_d   = opcode_q;
        vlm1_d     = vlm1_q;
        rd_cnt_d   = rd_cnt_q;
        addr_d     = addr_q;
        case (state_q)
            IDLE: begin
                if (bus.iss_valid) begin
                    opcode_d = bus.iss_opcode;
                    vlm1_d   = bus.iss_vlm1;
                    addr_d   = bus.iss_rbase;
                    rd_cnt_d = '0;
                    state_d  = RUN;
                end
            end
            RUN: begin
                if (rd_en_c) begin
                    rd_cnt_d = rd_cnt_q + VL_W'(1);
                    addr_d   = addr_q + RA_W'(1);
                    if (rd_cnt_q == vlm1_q) state_d = DRAIN;
                end
            end
            DRAIN: begin
                if (pop_c && skid_head.last) state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
        infl_d      = rd_en_c;
        infl_idx_d  = rd_en_c ? rd_cnt_q : infl_idx_q;
        iss_ready_d = (state_d == IDLE);
        busy_d      = (state_d != IDLE);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= IDLE;
            opcode_q    <= OP_NOP;
            vlm1_q      <= '0;
            rd_cnt_q    <= '0;
            addr_q      <= '0;
            infl_q      <= 1'b0;
            infl_idx_q  <= '0;
            iss_ready_q <= 1'b1;
            busy_q      <= 1'b0;
        end else begin
            state_q     <= state_d;
            opcode_q    <= opcode_d;
            vlm1_q      <= vlm1_d;
            rd_cnt_q    <= rd_cnt_d;
            addr_q      <= addr_d;
            infl_q      <= infl_d;
            infl_idx_q  <= infl_idx_d;
            iss_ready_q <= iss_ready_d;
            busy_q      <= busy_d;
        end
    end

    assign bus.iss_ready  = iss_ready_q;
    assign bus.rf_rd_en   = rd_en_c;
    assign bus.rf_rd_addr = addr_q;
    assign bus.sp_valid   = sp_valid_c;
    assign bus.sp_opcode  = opcode_q;
    assign bus.sp_op      = skid_head.op;
    assign bus.sp_idx     = VL_W'(skid_head.idx);
    assign bus.sp_last    = skid_head.last;
    assign busy           = busy_q;

`ifdef IP4_SPA_DISPATCH_PERF_EN
    logic [15:0] stall_q, stall_d;

    // Saturating count of cycles the SPA holds off an offered bundle.
    always_comb begin
        stall_d = stall_q;
        if (sp_valid_c && !bus.sp_ready && (stall_q != 16'hFFFF)) stall_d = stall_q + 16'd1;
    end

    always_ff @(posedge clk) begin
        if (rst) stall_q <= '0;
        else     stall_q <= stall_d;
    end

    assign stall_cnt = stall_q;
`else
    assign stall_cnt = '0;
`endif

endmodule

// File: tb/tb_ip4_rtl_spa_dispatch.sv
// tb_ip4_rtl_spa_dispatch: directed bench for ip4_rtl_spa_dispatch with a queue-based
// reference model (expected reads and bundles derived from each accepted instruction).
module tb_ip4_rtl_spa_dispatch;
    import ip4_rtl_spa_dispatch_pkg::*;

    logic        clk;
    logic        rst;
    logic        busy;
    logic [15:0] stall_cnt;

    ip4_rtl_spa_dispatch_if #(.VL_W(4), .RA_W(8)) bus ();

    ip4_rtl_spa_dispatch #(.MAX_VL(16), .VL_W(4), .RA_W(8)) dut (
        .clk       (clk),
        .rst       (rst),
        .bus       (bus),
        .busy      (busy),
        .stall_cnt (stall_cnt)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    int n_cmp  = 0;
    int n_fail = 0;

    typedef struct {
        logic [7:0] addr;
        logic [3:0] idx;
        logic       last;
        opcode_e    opc;
    } exp_t;

    typedef struct {
        logic [3:0] idx;
        logic       last;
        opcode_e    opc;
    } log_t;

    exp_t       exp_q[$];
    logic [7:0] addr_exp_q[$];
    log_t       acc_log[$];
    logic [7:0] rd_log[$];
    int         n_rd;
    int         n_pop;
    int         stall_m;
    exp_t       m_e;
    log_t       m_l;

    function automatic op_bundle_t row(input logic [7:0] a);
        op_bundle_t r;
        for (int i = 0; i < 3; i++)
            for (int j = 0; j < 4; j++)
                r[i][j] = {8'hD0, a, 8'(i), 8'(j)};
        return r;
    endfunction

    task automatic chk(input string name, input logic [383:0] act, input logic [383:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic step(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    // Register file: data for a read appears during the following cycle.
    logic       rd_pend;
    logic [7:0] rd_pend_addr;
    initial begin
        bus.rf_rd_data = '0;
        forever begin
            @(negedge clk);
            rd_pend      = bus.rf_rd_en;
            rd_pend_addr = bus.rf_rd_addr;
            @(posedge clk);
            #1;
            bus.rf_rd_data = rd_pend ? row(rd_pend_addr) : {12{32'hBAD0BAD0}};
        end
    end

    // Reference model and per-cycle compare.
    initial begin
        n_rd = 0; n_pop = 0; stall_m = 0;
        forever begin
            @(negedge clk);
            if (rst) begin
                exp_q.delete();
                addr_exp_q.delete();
                n_rd = 0; n_pop = 0; stall_m = 0;
            end else begin
                chk("busy", 384'(busy), 384'(exp_q.size() != 0));
                chk("iss_ready", 384'(bus.iss_ready), 384'(exp_q.size() == 0));
                chk("stall_cnt", 384'(stall_cnt), 384'(stall_m));
                chk("outstanding_le2", 384'((n_rd - n_pop) <= 2), 384'(1'b1));
                if (bus.rf_rd_en) begin
                    chk("read_expected", 384'(addr_exp_q.size() != 0), 384'(1'b1));
                    if (addr_exp_q.size() != 0)
                        chk("rd_addr", 384'(bus.rf_rd_addr), 384'(addr_exp_q.pop_front()));
                    rd_log.push_back(bus.rf_rd_addr);
                    n_rd++;
                end
                if (bus.sp_valid) begin
                    chk("bundle_expected", 384'(exp_q.size() != 0), 384'(1'b1));
                    if (exp_q.size() != 0) begin
                        m_e = exp_q[0];
                        chk("sp_idx", 384'(bus.sp_idx), 384'(m_e.idx));
                        chk("sp_last", 384'(bus.sp_last), 384'(m_e.last));
                        chk("sp_opcode", 384'(bus.sp_opcode), 384'(m_e.opc));
                        chk("sp_op", 384'(bus.sp_op), 384'(row(m_e.addr)));
                        if (bus.sp_ready) begin
                            void'(exp_q.pop_front());
                            n_pop++;
                            m_l.idx  = bus.sp_idx;
                            m_l.last = bus.sp_last;
                            m_l.opc  = bus.sp_opcode;
                            acc_log.push_back(m_l);
                        end
                    end
                end
                if (bus.iss_valid && bus.iss_ready) begin
                    for (int i = 0; i <= int'(bus.iss_vlm1); i++) begin
                        m_e.addr = bus.iss_rbase + 8'(i);
                        m_e.idx  = 4'(i);
                        m_e.last = (i == int'(bus.iss_vlm1));
                        m_e.opc  = bus.iss_opcode;
                        exp_q.push_back(m_e);
                        addr_exp_q.push_back(m_e.addr);
                    end
                end
`ifdef IP4_SPA_DISPATCH_PERF_EN
                if (bus.sp_valid && !bus.sp_ready && stall_m < 65535) stall_m++;
`endif
            end
        end
    end

    task automatic issue(input opcode_e op, input logic [3:0] vlm1, input logic [7:0] rb);
        int k = 0;
        while (!bus.iss_ready && k < 100) begin
            step(1);
            k++;
        end
        chk("issue_wait_timeout", 384'(k < 100), 384'(1'b1));
        bus.iss_valid  = 1'b1;
        bus.iss_opcode = op;
        bus.iss_vlm1   = vlm1;
        bus.iss_rbase  = rb;
        step(1);
        bus.iss_valid  = 1'b0;
    endtask

    task automatic wait_idle();
        int k = 0;
        while ((busy || bus.sp_valid) && k < 300) begin
            step(1);
            k++;
        end
        chk("idle_timeout", 384'(k < 300), 384'(1'b1));
    endtask

    logic [6:0] t1_rden;
    logic [6:0] t1_valid;
    logic [6:0] t1_ready;
    logic [7:0] t3_exp [4];
    logic [15:0] t6_stall;

    initial begin
        rst            = 1'b1;
        bus.iss_valid  = 1'b0;
        bus.iss_opcode = OP_NOP;
        bus.iss_vlm1   = '0;
        bus.iss_rbase  = '0;
        bus.sp_ready   = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        rst = 1'b0;

        // Reset state
        chk("rst_sp_valid", 384'(bus.sp_valid), 384'(1'b0));
        chk("rst_busy", 384'(busy), 384'(1'b0));
        chk("rst_iss_ready", 384'(bus.iss_ready), 384'(1'b1));
        chk("rst_rf_rd_en", 384'(bus.rf_rd_en), 384'(1'b0));
        chk("rst_rf_rd_addr", 384'(bus.rf_rd_addr), 384'(8'h00));
        chk("rst_sp_idx", 384'(bus.sp_idx), 384'(4'h0));
        chk("rst_sp_last", 384'(bus.sp_last), 384'(1'b0));
        chk("rst_sp_op", 384'(bus.sp_op), 384'(0));
        chk("rst_stall_cnt", 384'(stall_cnt), 384'(16'h0000));
        step(1);

        // VL=4 at 0x10, SPA always ready: cycle-exact schedule after acceptance
        t1_rden  = 7'b0001111;
        t1_valid = 7'b0111100;
        t1_ready = 7'b1000000;
        acc_log.delete();
        issue(OP_ADD, 4'd3, 8'h10);
        for (int c = 0; c < 7; c++) begin
            chk("t1_rf_rd_en", 384'(bus.rf_rd_en), 384'(t1_rden[c]));
            if (t1_rden[c]) chk("t1_rf_rd_addr", 384'(bus.rf_rd_addr), 384'(8'(8'h10 + c)));
            chk("t1_sp_valid", 384'(bus.sp_valid), 384'(t1_valid[c]));
            if (t1_valid[c]) begin
                chk("t1_sp_idx", 384'(bus.sp_idx), 384'(4'(c - 2)));
                chk("t1_sp_last", 384'(bus.sp_last), 384'(c == 5));
            end
            chk("t1_iss_ready", 384'(bus.iss_ready), 384'(t1_ready[c]));
            step(1);
        end
        wait_idle();
        chk("t1_count", 384'(acc_log.size()), 384'(4));

        // VL=8 with SPA back-pressure over cycles 3..7
        acc_log.delete();
        issue(OP_MUL, 4'd7, 8'h30);
        step(3);
        bus.sp_ready = 1'b0;
        step(2);
        chk("t2_reads_stopped", 384'(bus.rf_rd_en), 384'(1'b0));
        chk("t2_held_valid", 384'(bus.sp_valid), 384'(1'b1));
        chk("t2_held_idx", 384'(bus.sp_idx), 384'(4'd1));
        step(3);
        bus.sp_ready = 1'b1;
        wait_idle();
        chk("t2_count", 384'(acc_log.size()), 384'(8));
        for (int i = 0; i < acc_log.size(); i++) begin
            chk("t2_idx_seq", 384'(acc_log[i].idx), 384'(4'(i)));
            chk("t2_last_seq", 384'(acc_log[i].last), 384'(i == 7));
        end

        // Address wrap past the top row
        rd_log.delete();
        issue(OP_SUB, 4'd3, 8'hFE);
        wait_idle();
        t3_exp = '{8'hFE, 8'hFF, 8'h00, 8'h01};
        chk("t3_nreads", 384'(rd_log.size()), 384'(4));
        for (int i = 0; i < 4 && i < rd_log.size(); i++)
            chk("t3_addr", 384'(rd_log[i]), 384'(t3_exp[i]));

        // VL=1 back-to-back, opcodes MUL then SUB
        acc_log.delete();
        issue(OP_MUL, 4'd0, 8'h50);
        issue(OP_SUB, 4'd0, 8'h60);
        wait_idle();
        chk("t4_count", 384'(acc_log.size()), 384'(2));
        if (acc_log.size() == 2) begin
            chk("t4_a_opcode", 384'(acc_log[0].opc), 384'(OP_MUL));
            chk("t4_a_last", 384'(acc_log[0].last), 384'(1'b1));
            chk("t4_a_idx", 384'(acc_log[0].idx), 384'(4'd0));
            chk("t4_b_opcode", 384'(acc_log[1].opc), 384'(OP_SUB));
            chk("t4_b_last", 384'(acc_log[1].last), 384'(1'b1));
        end

        // Reset one cycle after the 3rd read of a VL=8 instruction
        issue(OP_MAC, 4'd7, 8'h40);
        step(3);
        rst = 1'b1;
        step(1);
        rst = 1'b0;
        chk("t5_sp_valid", 384'(bus.sp_valid), 384'(1'b0));
        chk("t5_busy", 384'(busy), 384'(1'b0));
        chk("t5_iss_ready", 384'(bus.iss_ready), 384'(1'b1));
        chk("t5_rf_rd_en", 384'(bus.rf_rd_en), 384'(1'b0));
        step(1);
        chk("t5_late_data_ignored", 384'(bus.sp_valid), 384'(1'b0));
        step(2);

        // SPA stalled for 10 cycles with a bundle offered
        bus.sp_ready = 1'b0;
        issue(OP_MAX, 4'd3, 8'h20);
        step(2);
        chk("t6_valid", 384'(bus.sp_valid), 384'(1'b1));
        step(10);
`ifdef IP4_SPA_DISPATCH_PERF_EN
        t6_stall = 16'd10;
`else
        t6_stall = 16'd0;
`endif
        chk("t6_stall_cnt", 384'(stall_cnt), 384'(t6_stall));
        bus.sp_ready = 1'b1;
        wait_idle();
        step(2);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish (got timeout expected completion)");
        $fatal(1, "watchdog");
    end

endmodule
